// File: rtl/bkm_pkg.sv
// ---------------------------------------------------------------------------
// bkm_pkg
// Shared definitions for the BKM control-path engine:
//   - digit codes sent to the log-LUT and to the value path
//   - FSM state encoding of the iterative controller
//   - threshold T(n) used by digit selection
//   - add/sub and clamp helpers used for the saturating update
// ---------------------------------------------------------------------------
package bkm_pkg;

    // Code 2'b10 is reserved and never produced.
    typedef enum logic [1:0] {
        D_ZERO = 2'b00,
        D_POS  = 2'b01,
        D_NEG  = 2'b11
    } digit_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // T(n) = 2^(dw-3-n) while that exponent is non-negative, 1 afterwards.
    function automatic longint threshold(input int n, input int dw);
        if (n <= dw - 3) begin
            return longint'(1) <<< (dw - 3 - n);
        end
        return longint'(1);
    endfunction

    // Exact sum/difference; 64 bits is far wider than any control variable,
    // so the result never wraps before it is clamped.
    function automatic longint addsub(input longint a, input longint b, input logic add);
        return add ? (a + b) : (a - b);
    endfunction

    // Clamp to the two's complement range of a dw-bit word.
    function automatic longint sat_clamp(input longint raw, input int dw);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (dw - 1)) - longint'(1);
        lo = -(longint'(1) <<< (dw - 1));
        if (raw > hi) begin
            return hi;
        end
        if (raw < lo) begin
            return lo;
        end
        return raw;
    endfunction

endpackage

// File: rtl/bkm_digit_sel.sv
// ---------------------------------------------------------------------------
// bkm_digit_sel
// Selects one BKM digit from a registered control variable and the current
// step index: +1 if x >= T(n), -1 if x <= -T(n), 0 otherwise.
// Ports:
//   i_x  DW-bit two's complement control variable (Q2.(DW-2))
//   i_n  step index
//   o_d  digit code (D_ZERO / D_POS / D_NEG)
// ---------------------------------------------------------------------------
module bkm_digit_sel
    import bkm_pkg::*;
#(
    parameter int DW    = 16,
    parameter int LOG2N = 6
) (
    input  logic [DW-1:0]    i_x,
    input  logic [LOG2N-1:0] i_n,
    output logic [1:0]       o_d
);

    longint w_x;
    longint w_thr;

    always_comb begin
        w_x   = longint'($signed(i_x));
        w_thr = threshold(int'(i_n), DW);
        if (w_x >= w_thr) begin
            o_d = D_POS;
        end else if (w_x <= -w_thr) begin
            o_d = D_NEG;
        end else begin
            o_d = D_ZERO;
        end
    end

endmodule

// File: rtl/bkm_control_iter.sv
// ---------------------------------------------------------------------------
// bkm_control_iter
// Iterative BKM control-path engine. Loads u_0/v_0 on start, then every step
// selects digits from u/v, presents them to an external log-LUT, streams the
// digit pair to the value path over valid/ready and updates u/v from the
// LUT reply with saturation. Runs n_max steps, then pulses done.
// Ports:
//   clk, arst_n, srst, enable    clock, async low reset, sync reset, clock enable
//   start, mode, n_max, u_0, v_0 run request and parameters (sampled in IDLE)
//   lut_n, lut_d_u, lut_d_v      step index and digits to the log-LUT
//   lut_u, lut_v                 combinational LUT reply
//   d_valid, d_ready, d_u, d_v, d_idx   digit stream to the value path
//   busy, done, u_res, v_res, ovf       status and results
// ---------------------------------------------------------------------------
module bkm_control_iter
    import bkm_pkg::*;
#(
    parameter int DW    = 16,
    parameter int N     = 64,
    parameter int LOG2N = 6
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             srst,
    input  logic             enable,
    input  logic             start,
    input  logic             mode,
    input  logic [LOG2N-1:0] n_max,
    input  logic [DW-1:0]    u_0,
    input  logic [DW-1:0]    v_0,
    output logic [LOG2N-1:0] lut_n,
    output logic [1:0]       lut_d_u,
    output logic [1:0]       lut_d_v,
    input  logic [DW-1:0]    lut_u,
    input  logic [DW-1:0]    lut_v,
    output logic             d_valid,
    input  logic             d_ready,
    output logic [1:0]       d_u,
    output logic [1:0]       d_v,
    output logic [LOG2N-1:0] d_idx,
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    u_res,
    output logic [DW-1:0]    v_res,
    output logic             ovf
);

    state_e           r_state;
    state_e           w_next_state;
    logic [LOG2N-1:0] r_n;
    logic [LOG2N-1:0] r_nmax;
    logic             r_mode;
    logic [DW-1:0]    r_u;
    logic [DW-1:0]    r_v;
    logic [DW-1:0]    r_ures;
    logic [DW-1:0]    r_vres;
    logic             r_ovf;

    logic [1:0]       w_du;
    logic [1:0]       w_dv;
    logic             w_hs;
    logic             w_last;
    longint           w_u_raw;
    longint           w_v_raw;
    longint           w_u_sat;
    longint           w_v_sat;
    logic             w_u_ovf;
    logic             w_v_ovf;

    bkm_digit_sel #(.DW(DW), .LOG2N(LOG2N)) u_sel_u (
        .i_x (r_u),
        .i_n (r_n),
        .o_d (w_du)
    );

    bkm_digit_sel #(.DW(DW), .LOG2N(LOG2N)) u_sel_v (
        .i_x (r_v),
        .i_n (r_n),
        .o_d (w_dv)
    );

    // mode 1 (L-mode) adds the LUT reply, mode 0 (E-mode) subtracts it.
    // Saturation is detected as any difference between exact and clamped value.
    always_comb begin
        w_u_raw = addsub(longint'($signed(r_u)), longint'($signed(lut_u)), r_mode);
        w_v_raw = addsub(longint'($signed(r_v)), longint'($signed(lut_v)), r_mode);
        w_u_sat = sat_clamp(w_u_raw, DW);
        w_v_sat = sat_clamp(w_v_raw, DW);
        w_u_ovf = (w_u_sat != w_u_raw);
        w_v_ovf = (w_v_sat != w_v_raw);
    end

    // The N-1 guard keeps the index from ever running past the LUT depth.
    assign w_last = (r_n == (r_nmax - LOG2N'(1))) || (int'(r_n) == N - 1);

    always_comb begin
        w_next_state = r_state;
        d_valid      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        w_hs         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (enable && start) begin
                    w_next_state = (n_max == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                d_valid = enable;
                w_hs    = enable && d_ready;
                if (w_hs && w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                // Held while disabled so the pulse is never lost.
                done = 1'b1;
                if (enable) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
        end else if (srst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_n    <= '0;
            r_nmax <= '0;
            r_mode <= 1'b0;
            r_u    <= '0;
            r_v    <= '0;
            r_ures <= '0;
            r_vres <= '0;
            r_ovf  <= 1'b0;
        end else if (srst) begin
            r_n    <= '0;
            r_nmax <= '0;
            r_mode <= 1'b0;
            r_u    <= '0;
            r_v    <= '0;
            r_ures <= '0;
            r_vres <= '0;
            r_ovf  <= 1'b0;
        end else if (enable) begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n    <= '0;
                        r_nmax <= n_max;
                        r_mode <= mode;
                        r_u    <= u_0;
                        r_v    <= v_0;
                        r_ovf  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (d_ready) begin
                        r_u <= w_u_sat[DW-1:0];
                        r_v <= w_v_sat[DW-1:0];
                        r_n <= r_n + LOG2N'(1);
                        if (w_u_ovf || w_v_ovf) begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_ures <= r_u;
                    r_vres <= r_v;
                end
                default: begin
                    r_n <= r_n;
                end
            endcase
        end
    end

    assign lut_n   = r_n;
    assign d_idx   = r_n;
    assign lut_d_u = w_du;
    assign lut_d_v = w_dv;
    assign d_u     = w_du;
    assign d_v     = w_dv;
    assign u_res   = r_ures;
    assign v_res   = r_vres;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_bkm_control_iter.sv
// ---------------------------------------------------------------------------
// tb_bkm_control_iter
// Directed bench for bkm_control_iter with a simple log-LUT model that
// replies with a fixed magnitude whenever the digit is non-zero.
// ---------------------------------------------------------------------------
module tb_bkm_control_iter;

    localparam int DW    = 16;
    localparam int LOG2N = 6;

    logic             clk = 1'b0;
    logic             arstN;
    logic             srst;
    logic             enable;
    logic             start;
    logic             mode;
    logic [LOG2N-1:0] nMax;
    logic [DW-1:0]    u0In;
    logic [DW-1:0]    v0In;
    logic [LOG2N-1:0] lutN;
    logic [1:0]       lutDU;
    logic [1:0]       lutDV;
    logic [DW-1:0]    lutU;
    logic [DW-1:0]    lutV;
    logic             dValid;
    logic             dReady;
    logic [1:0]       dU;
    logic [1:0]       dV;
    logic [LOG2N-1:0] dIdx;
    logic             busy;
    logic             done;
    logic [DW-1:0]    uRes;
    logic [DW-1:0]    vRes;
    logic             ovf;

    logic [DW-1:0]    lutMagU;
    logic [DW-1:0]    lutMagV;

    int compared   = 0;
    int mismatched = 0;

    bkm_control_iter #(.DW(DW), .N(64), .LOG2N(LOG2N)) dut (
        .clk     (clk),
        .arst_n  (arstN),
        .srst    (srst),
        .enable  (enable),
        .start   (start),
        .mode    (mode),
        .n_max   (nMax),
        .u_0     (u0In),
        .v_0     (v0In),
        .lut_n   (lutN),
        .lut_d_u (lutDU),
        .lut_d_v (lutDV),
        .lut_u   (lutU),
        .lut_v   (lutV),
        .d_valid (dValid),
        .d_ready (dReady),
        .d_u     (dU),
        .d_v     (dV),
        .d_idx   (dIdx),
        .busy    (busy),
        .done    (done),
        .u_res   (uRes),
        .v_res   (vRes),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // LUT stand-in: fixed magnitude for any non-zero digit, zero otherwise.
    always_comb begin
        lutU = (lutDU != 2'b00) ? lutMagU : '0;
        lutV = (lutDV != 2'b00) ? lutMagV : '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startRun(input logic m, input logic [LOG2N-1:0] nm,
                            input logic [DW-1:0] u0, input logic [DW-1:0] v0);
        mode  = m;
        nMax  = nm;
        u0In  = u0;
        v0In  = v0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        arstN = 1'b0; srst = 1'b0; enable = 1'b1; start = 1'b0; mode = 1'b0;
        nMax = '0; u0In = '0; v0In = '0; dReady = 1'b1;
        lutMagU = '0; lutMagV = '0;
        tick(); tick();
        arstN = 1'b1;
        tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        compared++; if (dValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dvalid: got %b want 0", dValid); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        compared++; if (dIdx !== 6'd0) begin mismatched++; $display("[TB] FAIL reset_idx: got %0d want 0", dIdx); end
        compared++; if (uRes !== 16'd0 || vRes !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_res: got %h/%h want 0000/0000", uRes, vRes); end
        compared++; if (ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ovf: got %b want 0", ovf); end
    endtask

    // E-mode, u: 16384 -> 12288 -> 8192 -> 4096, all digits +1.
    task automatic test_basic();
        lutMagU = 16'd4096; lutMagV = 16'd0; dReady = 1'b1;
        startRun(1'b0, 6'd3, 16'd16384, 16'd0);
        for (int i = 0; i < 3; i++) begin
            compared++; if (dValid !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_valid[%0d]: got %b want 1", i, dValid); end
            compared++; if (dIdx !== 6'(i) || lutN !== 6'(i)) begin mismatched++; $display("[TB] FAIL basic_idx[%0d]: got %0d/%0d want %0d", i, dIdx, lutN, i); end
            compared++; if (dU !== 2'b01 || lutDU !== 2'b01) begin mismatched++; $display("[TB] FAIL basic_du[%0d]: got %b/%b want 01", i, dU, lutDU); end
            compared++; if (dV !== 2'b00) begin mismatched++; $display("[TB] FAIL basic_dv[%0d]: got %b want 00", i, dV); end
            tick();
        end
        compared++; if (done !== 1'b1 || busy !== 1'b0 || dValid !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_done: got done=%b busy=%b valid=%b want 1 0 0", done, busy, dValid); end
        tick();
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_done_pulse: got %b want 0", done); end
        compared++; if (uRes !== 16'd4096 || vRes !== 16'd0) begin mismatched++; $display("[TB] FAIL basic_res: got %0d/%0d want 4096/0", uRes, vRes); end
        compared++; if (ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_abort();
        lutMagU = 16'd4096; lutMagV = 16'd0; dReady = 1'b1;
        startRun(1'b0, 6'd3, 16'd16384, 16'd0);
        tick(); tick();
        compared++; if (dIdx !== 6'd2) begin mismatched++; $display("[TB] FAIL abort_pre_idx: got %0d want 2", dIdx); end
        arstN = 1'b0;
        #1;
        compared++; if (busy !== 1'b0 || dValid !== 1'b0 || done !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_flags: got busy=%b valid=%b done=%b want 0 0 0", busy, dValid, done); end
        compared++; if (dIdx !== 6'd0 || uRes !== 16'd0 || ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_regs: got idx=%0d ures=%0d ovf=%b want 0 0 0", dIdx, uRes, ovf); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) arstN = 1'b1;
            compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_no_done[%0d]: got %b want 0", i, done); end
        end
        tick();
        startRun(1'b0, 6'd3, 16'd16384, 16'd0);
        tick(); tick(); tick();
        compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_rerun_done: got %b want 1", done); end
        tick();
        compared++; if (uRes !== 16'd4096) begin mismatched++; $display("[TB] FAIL abort_rerun_res: got %0d want 4096", uRes); end
    endtask

    task automatic test_backpressure();
        lutMagU = 16'd4096; lutMagV = 16'd0; dReady = 1'b1;
        startRun(1'b0, 6'd3, 16'd16384, 16'd0);
        tick();
        dReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            compared++; if (dValid !== 1'b1 || dIdx !== 6'd1 || dU !== 2'b01) begin mismatched++; $display("[TB] FAIL bp_stall[%0d]: got valid=%b idx=%0d du=%b want 1 1 01", i, dValid, dIdx, dU); end
        end
        dReady = 1'b1;
        tick();
        compared++; if (dIdx !== 6'd2 || dU !== 2'b01) begin mismatched++; $display("[TB] FAIL bp_resume: got idx=%0d du=%b want 2 01", dIdx, dU); end
        tick();
        compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_done: got %b want 1", done); end
        tick();
        compared++; if (uRes !== 16'd4096 || vRes !== 16'd0 || ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_res: got %0d/%0d ovf=%b want 4096/0 ovf=0", uRes, vRes, ovf); end
    endtask

    task automatic test_saturation();
        // L-mode: 32767 + 100 clamps to 32767.
        lutMagU = 16'd100; lutMagV = 16'd0; dReady = 1'b1;
        startRun(1'b1, 6'd1, 16'd32767, 16'd0);
        tick();
        compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_done: got %b want 1", done); end
        tick();
        compared++; if (uRes !== 16'h7FFF || ovf !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_pos: got %h ovf=%b want 7fff ovf=1", uRes, ovf); end
        // A new start clears the sticky flag immediately.
        lutMagU = 16'd4096;
        startRun(1'b0, 6'd1, 16'd16384, 16'd0);
        compared++; if (ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_clear: got %b want 0", ovf); end
        tick(); tick();
        compared++; if (uRes !== 16'd12288 || ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_clean_run: got %0d ovf=%b want 12288 ovf=0", uRes, ovf); end
        // E-mode: -32768 has digit -1; -32768 - 4096 clamps to -32768.
        startRun(1'b0, 6'd1, 16'h8000, 16'd0);
        compared++; if (dU !== 2'b11) begin mismatched++; $display("[TB] FAIL sat_neg_digit: got %b want 11", dU); end
        tick(); tick();
        compared++; if (uRes !== 16'h8000 || ovf !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_neg: got %h ovf=%b want 8000 ovf=1", uRes, ovf); end
    endtask

    task automatic test_nmax_zero();
        lutMagU = 16'd4096; lutMagV = 16'd4096; dReady = 1'b1;
        startRun(1'b0, 6'd0, 16'd1234, 16'hFFFB);
        compared++; if (done !== 1'b1 || dValid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL n0_done: got done=%b valid=%b busy=%b want 1 0 0", done, dValid, busy); end
        tick();
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL n0_pulse: got %b want 0", done); end
        compared++; if (uRes !== 16'd1234 || vRes !== 16'hFFFB) begin mismatched++; $display("[TB] FAIL n0_res: got %h/%h want 04d2/fffb", uRes, vRes); end
    endtask

    task automatic test_enable();
        lutMagU = 16'd4096; lutMagV = 16'd0; dReady = 1'b1;
        startRun(1'b0, 6'd3, 16'd16384, 16'd0);
        tick();
        enable = 1'b0;
        start  = 1'b1;
        #1;
        compared++; if (dValid !== 1'b0) begin mismatched++; $display("[TB] FAIL en_valid_low: got %b want 0", dValid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++; if (dIdx !== 6'd1 || busy !== 1'b1 || done !== 1'b0) begin mismatched++; $display("[TB] FAIL en_frozen[%0d]: got idx=%0d busy=%b done=%b want 1 1 0", i, dIdx, busy, done); end
        end
        enable = 1'b1;
        #1;
        compared++; if (dValid !== 1'b1 || dU !== 2'b01) begin mismatched++; $display("[TB] FAIL en_resume: got valid=%b du=%b want 1 01", dValid, dU); end
        tick();
        start = 1'b0;
        compared++; if (dIdx !== 6'd2 || busy !== 1'b1) begin mismatched++; $display("[TB] FAIL en_start_ignored: got idx=%0d busy=%b want 2 1", dIdx, busy); end
        tick();
        compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL en_done: got %b want 1", done); end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL en_done_stretch[%0d]: got %b want 1", i, done); end
        end
        enable = 1'b1;
        tick();
        compared++; if (done !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL en_idle: got done=%b busy=%b want 0 0", done, busy); end
        compared++; if (uRes !== 16'd4096 || ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL en_res: got %0d ovf=%b want 4096 ovf=0", uRes, ovf); end
    endtask

    task automatic test_threshold();
        logic [1:0] expU;
        logic [1:0] expV;
        lutMagU = '0; lutMagV = '0; dReady = 1'b1;
        // u=+1, v=-1 stay put; T(n) falls to 1 from n=13, where digits wake up.
        startRun(1'b1, 6'd16, 16'd1, 16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            expU = (i >= 13) ? 2'b01 : 2'b00;
            expV = (i >= 13) ? 2'b11 : 2'b00;
            compared++; if (dIdx !== 6'(i) || dU !== expU || dV !== expV) begin mismatched++; $display("[TB] FAIL thr_small[%0d]: got idx=%0d du=%b dv=%b want %0d %b %b", i, dIdx, dU, dV, i, expU, expV); end
            tick();
        end
        compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL thr_small_done: got %b want 1", done); end
        tick();
        compared++; if (uRes !== 16'd1 || vRes !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL thr_small_res: got %h/%h want 0001/ffff", uRes, vRes); end
        // Exactly at +/-T(0) = 8192 selects a non-zero digit; one inside does not.
        startRun(1'b0, 6'd1, 16'd8192, 16'hE000);
        compared++; if (dU !== 2'b01 || dV !== 2'b11) begin mismatched++; $display("[TB] FAIL thr_edge: got du=%b dv=%b want 01 11", dU, dV); end
        tick(); tick();
        startRun(1'b0, 6'd1, 16'd8191, 16'hE001);
        compared++; if (dU !== 2'b00 || dV !== 2'b00) begin mismatched++; $display("[TB] FAIL thr_inside: got du=%b dv=%b want 00 00", dU, dV); end
        tick(); tick();
        compared++; if (uRes !== 16'd8191 || vRes !== 16'hE001) begin mismatched++; $display("[TB] FAIL thr_inside_res: got %h/%h want 1fff/e001", uRes, vRes); end
    endtask

    // L-mode with negative v digits: -16384 -> -12288 -> -8192.
    task automatic test_neg_digits();
        lutMagU = 16'd4096; lutMagV = 16'd4096; dReady = 1'b1;
        startRun(1'b1, 6'd2, 16'd0, 16'hC000);
        for (int i = 0; i < 2; i++) begin
            compared++; if (dU !== 2'b00 || dV !== 2'b11 || lutDV !== 2'b11) begin mismatched++; $display("[TB] FAIL neg_digit[%0d]: got du=%b dv=%b lutdv=%b want 00 11 11", i, dU, dV, lutDV); end
            tick();
        end
        tick();
        compared++; if (uRes !== 16'd0 || vRes !== 16'hE000 || ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL neg_res: got %h/%h ovf=%b want 0000/e000 ovf=0", uRes, vRes, ovf); end
    endtask

    task automatic test_sync_reset();
        lutMagU = 16'd4096; lutMagV = 16'd0; dReady = 1'b1;
        startRun(1'b0, 6'd3, 16'd16384, 16'd0);
        tick();
        enable = 1'b0;
        srst   = 1'b1;
        tick();
        srst   = 1'b0;
        enable = 1'b1;
        compared++; if (busy !== 1'b0 || dValid !== 1'b0 || dIdx !== 6'd0) begin mismatched++; $display("[TB] FAIL srst_state: got busy=%b valid=%b idx=%0d want 0 0 0", busy, dValid, dIdx); end
        compared++; if (uRes !== 16'd0 || vRes !== 16'd0) begin mismatched++; $display("[TB] FAIL srst_res: got %h/%h want 0000/0000", uRes, vRes); end
        tick();
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL srst_no_done: got %b want 0", done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_backpressure();
        test_saturation();
        test_nmax_zero();
        test_enable();
        test_threshold();
        test_neg_digits();
        test_sync_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bkm_control_iter.md
Name: bkm_control_iter

Overview:
Iterative BKM control-path engine that runs the complete control recursion autonomously.
- Loads u_0/v_0, then each step selects digits d_u/d_v from the current control variables.
- Drives an external log-LUT with step index and digits; updates u/v from the LUT reply.
- Streams each digit pair to the value path over a valid/ready handshake.
- Sits between the FPU front end and the BKM value-path iterator. Successor to the single-step control block: adds internal digit selection, runtime iteration count, backpressure, saturation and start/done control.

Parameters:
DW, 16, control-variable width: two's complement, Q2.(DW-2).
N, 64, maximum iteration count.
LOG2N, 6, width of step index and n_max.

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
srst  in  1  synchronous reset, active high; clears state like arst_n; acts regardless of enable
enable  in  1  global clock enable; 0 freezes all state
start  in  1  start pulse, sampled only in IDLE
mode  in  1  0 = E-mode (u -= lut), 1 = L-mode (u += lut)
n_max  in  LOG2N  iterations to run (0..N-1)
u_0, v_0  in  DW  initial control variables
lut_n  out  LOG2N  current step index
lut_d_u, lut_d_v  out  2  current digits to LUT
lut_u, lut_v  in  DW  LUT reply; combinational, same cycle
d_valid  out  1  digit pair valid
d_ready  in  1  downstream accepts digit pair
d_u, d_v  out  2  digits
d_idx  out  LOG2N  step index of digit pair
busy  out  1  state is RUN
done  out  1  one-cycle completion pulse
u_res, v_res  out  DW  final control variables, held until next start
ovf  out  1  sticky saturation flag, cleared on accepted start

Behaviour:
- Reset (arst_n low or srst): state IDLE, n=0, u=v=0, u_res=v_res=0, ovf=0. d_valid, busy and done are 0. Reset mid-RUN aborts with no done pulse.
- Digit encoding: 00 = 0, 01 = +1, 11 = -1. Code 10 is never produced.
- Threshold: T(n) = 2^(DW-3-n) for n <= DW-3, else 1.
- Digit selection per component, from registered value x:
  - +1 if x >= T(n);
  - -1 if x <= -T(n);
  - 0 otherwise.
- Update: x_next = x - lut_x (mode 0) or x + lut_x (mode 1). Computed at DW+1 bits and saturated to [-2^(DW-1), 2^(DW-1)-1]. Any saturation sets ovf.
- The LUT is responsible for the digit-dependent sign and magnitude of lut_u/lut_v.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start & enable, latch u_0, v_0, mode, n_max; n=0; ovf=0. Go to RUN, or to DONE if n_max=0.
  - RUN: d_valid = enable. lut_n, d_idx = n. d_u/d_v and lut_d_u/lut_d_v are the selected digits. On d_valid & d_ready: update u, v; n++. If n == n_max-1 at that handshake, go to DONE.
  - DONE: done=1 for one cycle. u_res/v_res = u/v. Go to IDLE.
- start is ignored outside IDLE.
- While d_valid & !d_ready, d_u, d_v, d_idx, u and v stay stable.
- Latency with d_ready tied high: start sampled at edge k; handshakes at edges k+1..k+n_max; done high in cycle k+n_max+1.
- enable=0: no state, counter or register changes; d_valid=0; done stretches while disabled.
- mode and n_max are captured only at start.

Decomposition:
- Shared package bkm_pkg: digit codes (D_ZERO, D_POS, D_NEG), FSM state encodings, threshold function T(n), saturating add/sub function.
- One sub-module, bkm_digit_sel: combinational selection of one digit from value and n. Instantiated twice, once for u and once for v.

Test Plan:
1. Reset: assert arst_n=0 at step 2 of a run -> state IDLE, all outputs 0, no done pulse. Release, then start again -> normal run.
2. DW=16, mode 0, u_0=16384, v_0=0, n_max=3, LUT model lut_u=4096 when d_u!=0 else 0, lut_v=0, d_ready=1 -> d_u=+1,+1,+1 at d_idx 0,1,2 (u: 16384, 12288, 8192); d_v=0; done 4 cycles after start; u_res=4096, v_res=0, ovf=0.
3. Same as test 2 but d_ready=0 for 2 cycles at d_idx=1 -> d_valid stays high, d_u/d_idx stable, u holds 12288, done delayed 2 cycles, same results.
4. mode 1, u_0=32767, n_max=1, lut_u=100 -> u_res=32767, ovf=1. Next start -> ovf cleared.
5. n_max=0, u_0=1234 -> no d_valid; done the cycle after start; u_res=1234.
6. enable=0 for 3 cycles mid-run, plus a start pulse during RUN -> no handshakes and no state change while disabled; the start pulse is ignored; results identical to the undisturbed run, shifted 3 cycles.
